// File: rtl/corr_pkt_sched_pkg.sv
// Shared types and constants for the correlator packet scheduler.
package corr_pkt_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int PKT_LEN = 6;

  // Byte positions inside one packet
  localparam logic [2:0] PKT_HDR     = 3'd0;
  localparam logic [2:0] PKT_WIN     = 3'd1;
  localparam logic [2:0] PKT_X       = 3'd2;
  localparam logic [2:0] PKT_Y       = 3'd3;
  localparam logic [2:0] PKT_ISECT   = 3'd4;
  localparam logic [2:0] PKT_SYMDIFF = 3'd5;

  localparam int LOST_W = 4;

  // Saturating increment for the per-channel lost counters
  function automatic logic [LOST_W-1:0] lost_sat_inc(input logic [LOST_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/corr_pkt_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int CH_W = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [CH_W-1:0] grant_idx_o
);

  // Scan N positions starting at the pointer; the first active request wins
  always_comb begin
    int   cand;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = CH_W'(cand);
      end
    end
  end

endmodule

// File: rtl/corr_pkt_sched.sv
// Captures per-channel correlator results into holding slots and serialises
// one 6-byte packet per result into a shared byte-wide FIFO, round-robin.
module corr_pkt_sched
  import corr_pkt_sched_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cg,
  input  logic              i_flush,
  input  logic [N_CH-1:0]   i_res_valid,
  input  logic [8*N_CH-1:0] i_res_winNum,
  input  logic [32*N_CH-1:0] i_res_counts,
  output logic              o_fifo_push,
  output logic [7:0]        o_fifo_data,
  input  logic              i_fifo_full,
  output logic              o_busy
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     sel_q, sel_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]          idx_q, idx_d;

  logic [N_CH-1:0]     valid_q, valid_d;
  logic [7:0]          win_q  [N_CH];
  logic [7:0]          win_d  [N_CH];
  logic [31:0]         cnt_q  [N_CH];
  logic [31:0]         cnt_d  [N_CH];
  logic [LOST_W-1:0]   lost_q [N_CH];
  logic [LOST_W-1:0]   lost_d [N_CH];

  logic [N_CH-1:0]     grant;
  logic [CH_W-1:0]     grant_idx;
  logic                push;
  logic                hdr_push;
  logic                last_push;

  rr_arbiter #(
    .N    (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req_i       (valid_q),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // A byte leaves only while sending, enabled, not back-pressured and not flushing
  assign push      = (state_q == SEND) && i_cg && !i_fifo_full && !i_flush;
  assign hdr_push  = push && (idx_q == PKT_HDR);
  assign last_push = push && (idx_q == PKT_SYMDIFF);

  assign o_fifo_push = push;
  assign o_busy      = (|valid_q) || (state_q != IDLE);

  // Per-channel capture, drop accounting, and release of the slot being sent
  always_comb begin
    logic is_sel;
    logic freeing;
    logic drop;
    valid_d = valid_q;
    is_sel  = 1'b0;
    freeing = 1'b0;
    drop    = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      win_d[c]  = win_q[c];
      cnt_d[c]  = cnt_q[c];
      lost_d[c] = lost_q[c];
      is_sel    = (sel_q == CH_W'(c));
      // The slot being emptied this cycle may accept a new result at once
      freeing   = last_push && is_sel;
      drop      = i_res_valid[c] && valid_q[c] && !freeing;
      if (freeing) valid_d[c] = 1'b0;
      if (i_res_valid[c] && !drop) begin
        valid_d[c] = 1'b1;
        win_d[c]   = i_res_winNum[8*c +: 8];
        cnt_d[c]   = i_res_counts[32*c +: 32];
      end
      // Header push hands the count to the host; a same-cycle drop starts the next count at 1
      if (hdr_push && is_sel) lost_d[c] = drop ? LOST_W'(1) : '0;
      else if (drop)          lost_d[c] = lost_sat_inc(lost_q[c]);
      if (i_flush) begin
        valid_d[c] = 1'b0;
        win_d[c]   = '0;
        cnt_d[c]   = '0;
        lost_d[c]  = '0;
      end
    end
  end

  // Packet FSM: pick a slot in IDLE, step through its bytes in SEND
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          sel_d   = grant_idx;
          idx_d   = PKT_HDR;
          state_d = SEND;
        end
      end
      SEND: begin
        if (push) begin
          if (idx_q == 3'(PKT_LEN - 1)) begin
            idx_d    = PKT_HDR;
            state_d  = IDLE;
            rr_ptr_d = (sel_q == CH_W'(N_CH - 1)) ? '0 : sel_q + 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d  = IDLE;
      sel_d    = '0;
      idx_d    = PKT_HDR;
      rr_ptr_d = '0;
    end
  end

  // Output byte selected from the registered slot/index; no path from i_res_*
  always_comb begin
    logic [7:0]  cur_win;
    logic [31:0] cur_cnt;
    cur_win = win_q[sel_q];
    cur_cnt = cnt_q[sel_q];
    case (idx_q)
      PKT_HDR:     o_fifo_data = {4'(sel_q), lost_q[sel_q]};
      PKT_WIN:     o_fifo_data = cur_win;
      PKT_X:       o_fifo_data = cur_cnt[7:0];
      PKT_Y:       o_fifo_data = cur_cnt[15:8];
      PKT_ISECT:   o_fifo_data = cur_cnt[23:16];
      PKT_SYMDIFF: o_fifo_data = cur_cnt[31:24];
      default:     o_fifo_data = 8'h00;
    endcase
  end

  // State registers; everything holds while the clock gate is low
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      idx_q    <= PKT_HDR;
      valid_q  <= '0;
      for (int c = 0; c < N_CH; c++) begin
        win_q[c]  <= '0;
        cnt_q[c]  <= '0;
        lost_q[c] <= '0;
      end
    end else if (i_cg) begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      for (int c = 0; c < N_CH; c++) begin
        win_q[c]  <= win_d[c];
        cnt_q[c]  <= cnt_d[c];
        lost_q[c] <= lost_d[c];
      end
    end
  end

endmodule

// File: tb/tb_corr_pkt_sched.sv
// Bench for corr_pkt_sched: directed scenarios plus a randomized run
// compared cycle by cycle against a packet-level reference model.
module tb_corr_pkt_sched;

  localparam int N_CH = 4;

  logic                clk = 1'b0;
  logic                rstn;
  logic                cg;
  logic                flush;
  logic                full;
  logic [N_CH-1:0]     res_valid;
  logic [8*N_CH-1:0]   res_win;
  logic [32*N_CH-1:0]  res_cnt;
  logic                d_push;
  logic [7:0]          d_data;
  logic                d_busy;

  corr_pkt_sched #(.N_CH(N_CH)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_cg         (cg),
    .i_flush      (flush),
    .i_res_valid  (res_valid),
    .i_res_winNum (res_win),
    .i_res_counts (res_cnt),
    .o_fifo_push  (d_push),
    .o_fifo_data  (d_data),
    .i_fifo_full  (full),
    .o_busy       (d_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       obs_push, obs_busy;
  logic [7:0] obs_data;
  logic       exp_push, exp_busy;
  logic [7:0] exp_data;

  logic [7:0] got_data[$];
  int         got_cyc[$];

  // Reference model: slots as plain arrays, the packet in flight as a byte queue
  bit          m_full[N_CH];
  logic [7:0]  m_win[N_CH];
  logic [31:0] m_cnt[N_CH];
  int          m_lost[N_CH];
  bit          m_sending;
  int          m_ch;
  int          m_ptr;
  logic [7:0]  m_pkt[$];

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_full[c] = 0; m_win[c] = '0; m_cnt[c] = '0; m_lost[c] = 0;
    end
    m_sending = 0; m_ch = 0; m_ptr = 0; m_pkt.delete();
  endtask

  task automatic model_eval(input logic f, input logic fl, input logic g);
    logic [3:0] chn, lst;
    exp_push = m_sending && g && !f && !fl;
    chn = 4'(m_ch);
    lst = (m_sending) ? 4'(m_lost[m_ch]) : 4'h0;
    if (m_sending && m_pkt.size() == 6) exp_data = {chn, lst};
    else if (m_sending)                 exp_data = m_pkt[0];
    else                                exp_data = 8'h00;
    exp_busy = m_sending;
    for (int c = 0; c < N_CH; c++) if (m_full[c]) exp_busy = 1'b1;
  endtask

  task automatic model_step(input logic [N_CH-1:0] v, input logic fl, input logic g);
    bit pre_full[N_CH];
    bit pushed, hdr, last, cap, drop, found;
    int cc;
    if (!g) return;
    if (fl) begin
      model_reset();
      return;
    end
    pushed = exp_push;
    hdr    = pushed && m_pkt.size() == 6;
    last   = pushed && m_pkt.size() == 1;
    pre_full = m_full;
    for (int c = 0; c < N_CH; c++) begin
      cap = 0; drop = 0;
      if (v[c]) begin
        if (!pre_full[c] || (last && m_ch == c)) cap = 1;
        else drop = 1;
      end
      if (last && m_ch == c) m_full[c] = 0;
      if (cap) begin
        m_full[c] = 1;
        m_win[c]  = res_win[8*c +: 8];
        m_cnt[c]  = res_cnt[32*c +: 32];
      end
      if (hdr && m_ch == c)          m_lost[c] = drop ? 1 : 0;
      else if (drop && m_lost[c] < 15) m_lost[c] = m_lost[c] + 1;
    end
    if (m_sending) begin
      if (pushed) begin
        void'(m_pkt.pop_front());
        if (m_pkt.size() == 0) begin
          m_sending = 0;
          m_ptr = (m_ch + 1) % N_CH;
        end
      end
    end else begin
      found = 0;
      for (int k = 0; k < N_CH; k++) begin
        cc = (m_ptr + k) % N_CH;
        if (!found && pre_full[cc]) begin
          found = 1;
          m_sending = 1;
          m_ch = cc;
          m_pkt.delete();
          m_pkt.push_back(8'h00);
          m_pkt.push_back(m_win[cc]);
          m_pkt.push_back(m_cnt[cc][7:0]);
          m_pkt.push_back(m_cnt[cc][15:8]);
          m_pkt.push_back(m_cnt[cc][23:16]);
          m_pkt.push_back(m_cnt[cc][31:24]);
        end
      end
    end
  endtask

  task automatic set_res(input int c, input logic [7:0] w, input logic [31:0] k);
    res_win[8*c +: 8]   = w;
    res_cnt[32*c +: 32] = k;
  endtask

  // One clock: drive inputs, sample outputs at the falling edge, advance the model
  task automatic tick(input logic [N_CH-1:0] v, input logic f, input logic fl, input logic g);
    res_valid = v; full = f; flush = fl; cg = g;
    @(negedge clk);
    obs_push = d_push; obs_data = d_data; obs_busy = d_busy;
    model_eval(f, fl, g);
    if (obs_push === 1'b1) begin
      got_data.push_back(obs_data);
      got_cyc.push_back(cyc);
    end
    model_step(v, fl, g);
    cyc++;
    @(posedge clk); #1;
    res_valid = '0; full = 1'b0; flush = 1'b0; cg = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int k = 0; k < budget && got_data.size() < n; k++) tick('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; res_valid = '0; full = 1'b0; flush = 1'b0; cg = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
    got_data.delete(); got_cyc.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0; res_valid = '1; cg = 1'b1;
    @(posedge clk); #1;
    total++; if (d_push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b want=0", d_push); end
    total++; if (d_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", d_data); end
    total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", d_busy); end
    do_reset();
    tick('0, 1'b0, 1'b0, 1'b1);
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", obs_busy); end
  endtask

  task automatic test_single();
    logic [7:0] exp_b[6];
    int t0;
    exp_b = '{8'h20, 8'h11, 8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    set_res(2, 8'h11, 32'h44332211);
    t0 = cyc;
    tick(4'b0100, 1'b0, 1'b0, 1'b1);
    run_until(6, 20);
    total++;
    if (got_data.size() != 6) begin
      bad++; $display("FAIL single_count got=%0d want=6", got_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (got_data[i] !== exp_b[i]) begin bad++; $display("FAIL single_byte%0d got=%h want=%h", i, got_data[i], exp_b[i]); end
      end
      total++; if (got_cyc[0] != t0 + 2) begin bad++; $display("FAIL single_first_cyc got=%0d want=%0d", got_cyc[0], t0 + 2); end
      total++; if (got_cyc[5] != t0 + 7) begin bad++; $display("FAIL single_last_cyc got=%0d want=%0d", got_cyc[5], t0 + 7); end
    end
    tick('0, 1'b0, 1'b0, 1'b1);
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", obs_busy); end
  endtask

  task automatic test_round_robin();
    logic [7:0] hdr_exp[4];
    hdr_exp = '{8'h00, 8'h10, 8'h20, 8'h30};
    do_reset();
    for (int c = 0; c < N_CH; c++) set_res(c, 8'(8'h60 + c), $urandom);
    tick(4'b1111, 1'b0, 1'b0, 1'b1);
    run_until(24, 60);
    total++;
    if (got_data.size() != 24) begin
      bad++; $display("FAIL rr_count got=%0d want=24", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (got_data[6*i] !== hdr_exp[i]) begin bad++; $display("FAIL rr_hdr%0d got=%h want=%h", i, got_data[6*i], hdr_exp[i]); end
        total++; if (got_data[6*i+1] !== 8'(8'h60 + i)) begin bad++; $display("FAIL rr_win%0d got=%h want=%h", i, got_data[6*i+1], 8'(8'h60 + i)); end
      end
    end
    set_res(0, 8'hC0, 32'h0);
    set_res(3, 8'hC3, 32'h0);
    tick(4'b1001, 1'b0, 1'b0, 1'b1);
    run_until(36, 40);
    total++;
    if (got_data.size() != 36) begin
      bad++; $display("FAIL rr2_count got=%0d want=36", got_data.size());
    end else begin
      total++; if (got_data[24] !== 8'h00) begin bad++; $display("FAIL rr2_first_hdr got=%h want=00", got_data[24]); end
      total++; if (got_data[30] !== 8'h30) begin bad++; $display("FAIL rr2_second_hdr got=%h want=30", got_data[30]); end
    end
  endtask

  task automatic test_drops();
    bit dropped;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_res(1, 8'(8'h40 + i), (i == 0) ? 32'h04030201 : 32'hEEEEEEEE);
      tick(4'b0010, 1'b1, 1'b0, 1'b1);
    end
    total++; if (got_data.size() != 0) begin bad++; $display("FAIL drop_push_while_full got=%0d want=0", got_data.size()); end
    dropped = 0;
    for (int k = 0; k < 40 && got_data.size() < 6; k++) begin
      if (got_data.size() == 2 && !dropped) begin
        set_res(1, 8'h99, 32'h0);
        dropped = 1;
        tick(4'b0010, 1'b0, 1'b0, 1'b1);
      end else begin
        tick('0, 1'b0, 1'b0, 1'b1);
      end
    end
    total++;
    if (got_data.size() != 6) begin
      bad++; $display("FAIL drop_count got=%0d want=6", got_data.size());
    end else begin
      total++; if (got_data[0] !== 8'h1F) begin bad++; $display("FAIL drop_hdr got=%h want=1f", got_data[0]); end
      total++; if (got_data[1] !== 8'h40) begin bad++; $display("FAIL drop_win got=%h want=40", got_data[1]); end
      total++; if (got_data[2] !== 8'h01) begin bad++; $display("FAIL drop_x got=%h want=01", got_data[2]); end
      total++; if (got_data[5] !== 8'h04) begin bad++; $display("FAIL drop_symdiff got=%h want=04", got_data[5]); end
    end
    set_res(1, 8'h77, 32'h0);
    tick(4'b0010, 1'b0, 1'b0, 1'b1);
    run_until(12, 30);
    total++;
    if (got_data.size() != 12) begin
      bad++; $display("FAIL drop2_count got=%0d want=12", got_data.size());
    end else begin
      total++; if (got_data[6] !== 8'h11) begin bad++; $display("FAIL drop2_hdr got=%h want=11", got_data[6]); end
      total++; if (got_data[7] !== 8'h77) begin bad++; $display("FAIL drop2_win got=%h want=77", got_data[7]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b[6];
    logic f;
    exp_b = '{8'h20, 8'h5A, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    do_reset();
    set_res(2, 8'h5A, 32'h0D0C0B0A);
    tick(4'b0100, 1'b0, 1'b0, 1'b1);
    f = 1'b0;
    for (int k = 0; k < 40 && got_data.size() < 6; k++) begin
      f = (got_data.size() > 0) ? !f : 1'b0;
      tick('0, f, 1'b0, 1'b1);
    end
    total++;
    if (got_data.size() != 6) begin
      bad++; $display("FAIL bp_count got=%0d want=6", got_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++; if (got_data[i] !== exp_b[i]) begin bad++; $display("FAIL bp_byte%0d got=%h want=%h", i, got_data[i], exp_b[i]); end
      end
      total++; if (got_cyc[5] - got_cyc[0] + 1 != 11) begin bad++; $display("FAIL bp_span got=%0d want=11", got_cyc[5] - got_cyc[0] + 1); end
    end
  endtask

  task automatic test_back_to_back();
    bit sent2;
    do_reset();
    set_res(0, 8'hA1, 32'h11111111);
    tick(4'b0001, 1'b0, 1'b0, 1'b1);
    sent2 = 0;
    for (int k = 0; k < 40 && got_data.size() < 12; k++) begin
      if (got_data.size() == 5 && !sent2) begin
        set_res(0, 8'hA2, 32'h22222222);
        sent2 = 1;
        tick(4'b0001, 1'b0, 1'b0, 1'b1);
      end else begin
        tick('0, 1'b0, 1'b0, 1'b1);
      end
    end
    total++;
    if (got_data.size() != 12) begin
      bad++; $display("FAIL b2b_count got=%0d want=12", got_data.size());
    end else begin
      total++; if (got_data[6] !== 8'h00) begin bad++; $display("FAIL b2b_hdr got=%h want=00", got_data[6]); end
      total++; if (got_data[7] !== 8'hA2) begin bad++; $display("FAIL b2b_win got=%h want=a2", got_data[7]); end
      total++; if (got_cyc[6] - got_cyc[5] != 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", got_cyc[6] - got_cyc[5]); end
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_res(1, 8'hB1, 32'h0);
    tick(4'b0010, 1'b0, 1'b0, 1'b1);
    run_until(6, 20);
    set_res(2, 8'hB2, 32'h0);
    tick(4'b0100, 1'b0, 1'b0, 1'b1);
    run_until(9, 20);
    // byte 3 of ch2 is due now; flush together with a ch3 strobe
    tick(4'b1000, 1'b0, 1'b1, 1'b1);
    total++; if (obs_push !== 1'b0) begin bad++; $display("FAIL flush_push got=%b want=0", obs_push); end
    repeat (10) tick('0, 1'b0, 1'b0, 1'b1);
    total++; if (got_data.size() != 9) begin bad++; $display("FAIL flush_extra_push got=%0d want=9", got_data.size()); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", obs_busy); end
    set_res(0, 8'hC0, 32'h0);
    set_res(3, 8'hC3, 32'h0);
    tick(4'b1001, 1'b0, 1'b0, 1'b1);
    run_until(17, 30);
    total++;
    if (got_data.size() != 17) begin
      bad++; $display("FAIL flush_rr_count got=%0d want=17", got_data.size());
    end else begin
      total++; if (got_data[9] !== 8'h00) begin bad++; $display("FAIL flush_rrptr_hdr got=%h want=00", got_data[9]); end
    end
    // mid-packet of ch3 (byte 2 due): asynchronous reset between edges
    #2 rstn = 1'b0;
    #1;
    total++; if (d_push !== 1'b0) begin bad++; $display("FAIL rst_push got=%b want=0", d_push); end
    total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", d_busy); end
    total++; if (d_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", d_data); end
    @(posedge clk); #1 rstn = 1'b1;
    model_reset();
    repeat (10) tick('0, 1'b0, 1'b0, 1'b1);
    total++; if (got_data.size() != 17) begin bad++; $display("FAIL rst_extra_push got=%0d want=17", got_data.size()); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL rst_busy_after got=%b want=0", obs_busy); end
    tick(4'b1001, 1'b0, 1'b0, 1'b1);
    run_until(18, 10);
    total++;
    if (got_data.size() < 18) begin
      bad++; $display("FAIL rst_rr_count got=%0d want=18", got_data.size());
    end else begin
      total++; if (got_data[17] !== 8'h00) begin bad++; $display("FAIL rst_rrptr_hdr got=%h want=00", got_data[17]); end
    end
  endtask

  task automatic test_random();
    logic [N_CH-1:0] v;
    logic f, fl, g;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        v[c] = ($urandom_range(0, 9) == 0);
        set_res(c, 8'($urandom), $urandom);
      end
      f  = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 249) == 0);
      g  = ($urandom_range(0, 19) != 0);
      tick(v, f, fl, g);
      total++; if (obs_push !== exp_push) begin bad++; $display("FAIL rand_push cyc=%0d got=%b want=%b", cyc, obs_push, exp_push); end
      total++; if (obs_busy !== exp_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, obs_busy, exp_busy); end
      if (exp_push) begin
        total++; if (obs_data !== exp_data) begin bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, obs_data, exp_data); end
      end
    end
  endtask

  initial begin
    rstn = 1'b0; cg = 1'b1; flush = 1'b0; full = 1'b0;
    res_valid = '0; res_win = '0; res_cnt = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_drops();
    test_backpressure();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
